keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment driver: scans a 4x4 matrix keypad one column at a time, reads the row lines, debounces, and emits a 4-bit key code with a one-cycle valid strobe.
- Column lines are active low, like the display anodes, and are driven through the same style of open-drain/PNP buffer.
- Rows are pulled up externally, so a pressed key reads 0.
- Sits between the board keypad header and any consumer of hex digits, e.g. the value register feeding the display mux.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_scanner.sv | 123 ++++++++++++
 tb/tb_keypad_scanner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, FSM states and snapshot decode for the keypad scanner
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;
  localparam int SNAP_W   = NUM_ROWS * NUM_COLS;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  typedef struct packed {
    logic             one;
    logic [KEY_W-1:0] code;
  } decode_t;

  // Snapshot bit index is {row, col}, so the index of a lone set bit is its key code.
  function automatic decode_t decode_snapshot(input logic [SNAP_W-1:0] snap);
    decode_t d;
    int      n;
    d = '0;
    n = 0;
    for (int i = 0; i < SNAP_W; i++) begin
      if (snap[i]) begin
        n++;
        d.code = i[KEY_W-1:0];
      end
    end
    d.one = (n == 1);
    return d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with a configurable reset value
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with scan-level debounce
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_SAT  = MW'(DEBOUNCE - 1);

  logic [3:0]        rows_sync;
  logic [DW-1:0]     dwell;
  logic [1:0]        col;
  logic [SNAP_W-1:0] snap, prev_snap, full_snap;
  logic [MW-1:0]     match_cnt, match_next;
  logic              sample, scan_end, stable;
  decode_t           dec;
  state_t            state, state_next;
  logic [3:0]        key_next;
  logic              valid_next, down_next;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (rows),
    .q   (rows_sync)
  );

  assign sample   = (dwell == DWELL_LAST);
  assign scan_end = sample && (col == 2'd3);

  // The column being sampled is merged in combinationally so the column-3
  // sample can be judged in the same cycle it is taken.
  always_comb begin
    full_snap = snap;
    for (int r = 0; r < NUM_ROWS; r++) begin
      full_snap[{r[1:0], col}] = ~rows_sync[r];
    end
  end

  always_comb begin
    match_next = '0;
    if (full_snap == prev_snap) begin
      match_next = (match_cnt == MATCH_SAT) ? match_cnt : match_cnt + MW'(1);
    end
  end

  assign stable = scan_end && (match_next == MATCH_SAT);
  assign dec    = decode_snapshot(full_snap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell     <= '0;
      col       <= 2'd0;
      cols      <= 4'b1110;
      snap      <= '0;
      prev_snap <= '0;
      match_cnt <= '0;
    end else if (sample) begin
      dwell <= '0;
      col   <= col + 2'd1;
      cols  <= {cols[2:0], cols[3]};
      snap  <= full_snap;
      if (col == 2'd3) begin
        prev_snap <= full_snap;
        match_cnt <= match_next;
      end
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // A new press is only accepted from IDLE, which is reached solely via a debounced full release.
  always_comb begin
    state_next = state;
    key_next   = key;
    valid_next = 1'b0;
    down_next  = key_down;
    case (state)
      IDLE: begin
        if (stable && dec.one) begin
          key_next   = dec.code;
          valid_next = 1'b1;
          down_next  = 1'b1;
          state_next = PRESSED;
        end
      end
      PRESSED: begin
        if (stable && (full_snap == '0)) begin
          down_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_next;
      key       <= key_next;
      key_valid <= valid_next;
      key_down  <= down_next;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner against a scan-level reference model
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DEB  = 3;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_down;
  logic [15:0] mask = 16'h0000;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulses   = 0;
  int          pulse_k  = -1;

  int          k;
  logic [15:0] hist[$];
  logic [15:0] scans[$];
  logic        held;
  logic [3:0]  exp_key;
  logic        exp_valid;
  logic        exp_down;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Physical keypad: a row reads low if any pressed key on it sits in a driven (low) column.
  function automatic logic [3:0] pad_rows(input logic [15:0] m, input logic [3:0] c);
    logic [3:0] r_out;
    r_out = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (!c[cc] && m[{r[1:0], cc[1:0]}]) r_out[r] = 1'b0;
    return r_out;
  endfunction

  assign rows = pad_rows(mask, cols);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k         = 0;
    hist      = {16'h0000};
    scans     = {16'h0000};
    held      = 1'b0;
    exp_key   = 4'h0;
    exp_valid = 1'b0;
    exp_down  = 1'b0;
  endtask

  // Column c of the scan ending at edge k is sampled at edge k-SCAN+(c+1)*SD and
  // sees the keypad as it was two edges earlier.
  task automatic model_edge();
    logic [15:0] snap;
    logic        stable;
    int          kc;
    k++;
    hist.push_back(mask);
    exp_valid = 1'b0;
    if (k % SCAN == 0) begin
      snap = 16'h0000;
      for (int c = 0; c < 4; c++) begin
        kc = k - SCAN + (c + 1) * SD;
        for (int r = 0; r < 4; r++)
          if (hist[kc-2][{r[1:0], c[1:0]}]) snap[{r[1:0], c[1:0]}] = 1'b1;
      end
      scans.push_back(snap);
      if (scans.size() > DEB) void'(scans.pop_front());
      stable = (scans.size() == DEB);
      for (int i = 0; i < scans.size(); i++)
        if (scans[i] != snap) stable = 1'b0;
      if (stable) begin
        if (!held && $countones(snap) == 1) begin
          held      = 1'b1;
          exp_valid = 1'b1;
          exp_down  = 1'b1;
          for (int i = 0; i < 16; i++) if (snap[i]) exp_key = i[3:0];
        end else if (held && snap == 16'h0000) begin
          held     = 1'b0;
          exp_down = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    logic [3:0] one4;
    logic [3:0] exp_cols;
    @(posedge clk);
    model_edge();
    #1;
    one4     = 4'b0001;
    exp_cols = ~(one4 << ((k / SD) % 4));
    check("cols", {12'h0, cols}, {12'h0, exp_cols});
    check("key_valid", {15'h0, key_valid}, {15'h0, exp_valid});
    check("key_down", {15'h0, key_down}, {15'h0, exp_down});
    check("key", {12'h0, key}, {12'h0, exp_key});
    if (key_valid) begin
      pulses++;
      pulse_k = k;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_cols", {12'h0, cols}, 16'h000e);
    check("rst_key", {12'h0, key}, 16'h0000);
    check("rst_key_valid", {15'h0, key_valid}, 16'h0000);
    check("rst_key_down", {15'h0, key_down}, 16'h0000);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int sel;
    do_reset(3);

    pulses = 0;
    run(64);
    check("idle_pulses", 16'(pulses), 16'd0);

    pulses = 0;
    mask = 16'h0200;
    run(260);
    check("press9_pulses", 16'(pulses), 16'd1);
    check("press9_key", {12'h0, key}, 16'h0009);
    check("press9_down", {15'h0, key_down}, 16'h0001);

    mask = 16'h0000;
    run(80);
    check("release_down", {15'h0, key_down}, 16'h0000);
    check("release_key", {12'h0, key}, 16'h0009);

    pulses = 0;
    mask = 16'h0008;
    run(100);
    check("press3_pulses", 16'(pulses), 16'd1);
    check("press3_key", {12'h0, key}, 16'h0003);
    mask = 16'h0000;
    run(80);

    repeat (16) begin
      mask = mask ^ 16'h0200;
      run(10);
    end
    mask = 16'h0000;
    run(80);

    pulses = 0;
    mask = 16'h0044;
    run(160);
    check("multi_pulses", 16'(pulses), 16'd0);
    mask = 16'h0000;
    run(80);
    pulses = 0;
    mask = 16'h0040;
    run(100);
    check("press6_pulses", 16'(pulses), 16'd1);
    check("press6_key", {12'h0, key}, 16'h0006);

    do_reset(3);
    pulses  = 0;
    pulse_k = -1;
    run(100);
    check("post_reset_pulses", 16'(pulses), 16'd1);
    check("post_reset_latency", 16'(pulse_k), 16'(3 * SCAN));
    check("post_reset_key", {12'h0, key}, 16'h0006);

    mask = 16'h0000;
    run(80);
    repeat (40) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4) mask = 16'h0000;
      else if (sel < 9) mask = 16'h0001 << $urandom_range(0, 15);
      else mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      run(int'($urandom_range(5, 60)));
    end
    mask = 16'h0000;
    run(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
